// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC result read-back path.
// Holds the default cell width, index width, FSM state encoding
// and a width-agnostic signed greater-than used by the argmax tracker.
package fc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IDX_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        SEND,
        DONE
    } state_t;

    // Callers sign-extend their operands to 64 bits so one helper serves any DATA_W.
    function automatic logic signed_gt(input logic signed [63:0] a,
                                       input logic signed [63:0] b);
        return (a > b);
    endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running signed argmax over a stream of (idx, val) updates.
// Latency: best_idx/best_val reflect an update one cycle after upd.
// No backpressure: accepts one update per cycle whenever upd is high.
module fc_argmax_tracker
    import fc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              upd,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] val,
    output logic [IDX_W-1:0]  best_idx,
    output logic [DATA_W-1:0] best_val
);

    // Set after clear so the first cell loads regardless of the stale best value.
    logic first;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first    <= 1'b1;
            best_idx <= '0;
            best_val <= '0;
        end else if (clear) begin
            first    <= 1'b1;
            best_idx <= '0;
            best_val <= '0;
        end else if (upd) begin
            first <= 1'b0;
            if (first || signed_gt(64'($signed(val)), 64'($signed(best_val)))) begin
                best_idx <= idx;
                best_val <= val;
            end
        end
    end

endmodule

// File: rtl/fc_result_reader.sv
// Reads BCK_CELL FC output cells from RAM, streams them out and reports the signed argmax.
// Latency: start edge -> out_valid after 3 clocks; 3 clocks per cell when out_ready is high.
// Backpressure: out_data/out_idx/out_last hold and no new read is issued until out_ready.
// Build option FC_RELU_EN clamps negative cells to zero before output and compare.
module fc_result_reader
    import fc_pkg::*;
#(
    parameter int BCK_CELL  = 5,
    parameter int BASE_ADDR = 0,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_val
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BCK_CELL - 1);

    state_t            state;
    logic              start_d;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] cell_val;
    logic [IDX_W-1:0]  best_idx;
    logic [DATA_W-1:0] best_val;
    logic              run_start;

    assign run_start = (state == IDLE) && start && !start_d;
    assign mem_we    = 1'b0;

    // Cell value as seen by both the output stream and the argmax compare.
    always_comb begin
        cell_val = mem_q;
`ifdef FC_RELU_EN
        if (mem_q[DATA_W-1]) begin
            cell_val = '0;
        end
`endif
    end

    fc_argmax_tracker #(
        .DATA_W (DATA_W)
    ) u_argmax (
        .clk      (clk),
        .reset    (reset),
        .clear    (run_start),
        .upd      (state == WAIT),
        .idx      (cnt),
        .val      (cell_val),
        .best_idx (best_idx),
        .best_val (best_val)
    );

    // Read/stream sequencer: one RAM read per cell, held until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            start_d   <= 1'b1;
            cnt       <= '0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_idx <= '0;
            class_val <= '0;
        end else begin
            start_d <= start;
            case (state)
                IDLE: begin
                    if (run_start) begin
                        cnt       <= '0;
                        done      <= 1'b0;
                        class_idx <= '0;
                        class_val <= '0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    mem_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(cnt);
                    busy     <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    out_data  <= cell_val;
                    out_idx   <= cnt;
                    out_last  <= (cnt == LAST_IDX);
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            class_idx <= best_idx;
                            class_val <= best_val;
                            state     <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ADDR;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_result_reader.sv
// Directed bench for fc_result_reader: streaming order, backpressure hold,
// argmax ties/negatives, mid-run reset, ignored restart, single-cell build.
module tb_fc_result_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_q;
    logic        out_valid;
    logic        ready;
    logic [15:0] out_data;
    logic [7:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [7:0]  class_idx;
    logic [15:0] class_val;

    logic        b_start;
    logic [15:0] b_mem_addr;
    logic        b_mem_we;
    logic [15:0] b_mem_q;
    logic        b_out_valid;
    logic        b_ready;
    logic [15:0] b_out_data;
    logic [7:0]  b_out_idx;
    logic        b_out_last;
    logic        b_busy;
    logic        b_done;
    logic [7:0]  b_class_idx;
    logic [15:0] b_class_val;

    logic [15:0] ram [0:31];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational-read RAM: data for an address is ready by the following edge.
    assign mem_q   = (mem_addr < 16'd32)   ? ram[mem_addr[4:0]]   : 16'h0;
    assign b_mem_q = (b_mem_addr < 16'd32) ? ram[b_mem_addr[4:0]] : 16'h0;

    fc_result_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .out_valid (out_valid),
        .out_ready (ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx),
        .class_val (class_val)
    );

    fc_result_reader #(
        .BCK_CELL  (1),
        .BASE_ADDR (20)
    ) dut_single (
        .clk       (clk),
        .reset     (reset),
        .start     (b_start),
        .mem_addr  (b_mem_addr),
        .mem_we    (b_mem_we),
        .mem_q     (b_mem_q),
        .out_valid (b_out_valid),
        .out_ready (b_ready),
        .out_data  (b_out_data),
        .out_idx   (b_out_idx),
        .out_last  (b_out_last),
        .busy      (b_busy),
        .done      (b_done),
        .class_idx (b_class_idx),
        .class_val (b_class_val)
    );

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef FC_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(tag, {31'b0, out_valid}, 32'd1);
    endtask

    // Full 5-cell run on the main instance; expected class values hand-computed by caller.
    task automatic do_run(input int stall_beat, input int pulse_beat, input bit chk_lat,
                          input logic [7:0] exp_idx, input logic [15:0] exp_val);
        start = 1'b1;
        if (chk_lat) begin
            @(negedge clk);
            @(negedge clk);
            chk("lat_busy", {31'b0, busy}, 32'd1);
            chk("lat_not_yet", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
            chk("lat_valid", {31'b0, out_valid}, 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            ready = (k != stall_beat);
            wait_valid("beat_valid");
            chk("beat_idx", {24'b0, out_idx}, k);
            chk("beat_data", {16'b0, out_data}, {16'b0, relu(ram[k])});
            chk("beat_last", {31'b0, out_last}, {31'b0, (k == 4)});
            chk("beat_addr", {16'b0, mem_addr}, k);
            chk("done_low", {31'b0, done}, 32'd0);
            if (k == stall_beat) begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_valid", {31'b0, out_valid}, 32'd1);
                    chk("stall_data", {16'b0, out_data}, {16'b0, relu(ram[k])});
                    chk("stall_idx", {24'b0, out_idx}, k);
                    chk("stall_addr", {16'b0, mem_addr}, k);
                end
                ready = 1'b1;
            end
            if (k == pulse_beat) start = 1'b0;
            @(negedge clk);
            chk("hs_drop", {31'b0, out_valid}, 32'd0);
            if (k == pulse_beat) start = 1'b1;
        end
        chk("run_done", {31'b0, done}, 32'd1);
        chk("run_busy", {31'b0, busy}, 32'd0);
        chk("run_class_idx", {24'b0, class_idx}, {24'b0, exp_idx});
        chk("run_class_val", {16'b0, class_val}, {16'b0, exp_val});
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_done_hold", {31'b0, done}, 32'd1);
        chk("idle_class_hold", {8'b0, class_idx, class_val}, {8'b0, exp_idx, exp_val});
        ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        ready   = 1'b1;
        b_start = 1'b0;
        b_ready = 1'b1;
        for (int i = 0; i < 32; i++) ram[i] = 16'h0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_outs", {out_valid, out_last, busy, done, out_idx, out_data},
            32'd0);
        chk("rst_class", {8'b0, class_idx, class_val}, 32'd0);
        chk("rst_addr_we", {15'b0, mem_we, mem_addr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Run 1: {3,-7,12,12,5}, tie keeps idx 2
        ram[0] = 16'd3; ram[1] = 16'hFFF9; ram[2] = 16'd12; ram[3] = 16'd12; ram[4] = 16'd5;
        do_run(-1, -1, 1'b1, 8'd2, 16'd12);

        // Run 2: same data, beat 1 stalled for 4 cycles
        do_run(1, -1, 1'b0, 8'd2, 16'd12);

        // Run 3: all negative
        ram[0] = 16'hFFF7; ram[1] = 16'hFFFC; ram[2] = 16'hFFEC; ram[3] = 16'hFFFC; ram[4] = 16'hFFE2;
`ifdef FC_RELU_EN
        do_run(-1, -1, 1'b0, 8'd0, 16'h0000);
`else
        do_run(-1, -1, 1'b0, 8'd1, 16'hFFFC);
`endif

        // Reset during beat 2 with start held high
        ram[0] = 16'd3; ram[1] = 16'hFFF9; ram[2] = 16'd12; ram[3] = 16'd12; ram[4] = 16'd5;
        start = 1'b1;
        begin
            int t = 0;
            while (!(out_valid === 1'b1 && out_idx === 8'd2) && t < 40) begin
                @(negedge clk);
                t++;
            end
        end
        chk("reach_beat2", {24'b0, out_idx}, 32'd2);
        reset = 1'b1;
        #1;
        chk("midrst_outs", {out_valid, out_last, busy, done, out_idx, out_data}, 32'd0);
        chk("midrst_class", {8'b0, class_idx, class_val}, 32'd0);
        chk("midrst_addr", {16'b0, mem_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_start_no_run", {30'b0, busy, out_valid}, 32'd0);
        chk("held_start_no_done", {31'b0, done}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        do_run(-1, -1, 1'b0, 8'd2, 16'd12);

        // Extra start pulse while busy, then a second run
        do_run(-1, 1, 1'b0, 8'd2, 16'd12);
        ram[0] = 16'd1; ram[1] = 16'd2; ram[2] = 16'd3; ram[3] = 16'd4; ram[4] = 16'd100;
        do_run(-1, -1, 1'b0, 8'd4, 16'd100);

        // Single-cell instance at BASE_ADDR 20
        ram[20] = 16'h8000;
        b_start = 1'b1;
        begin
            int t = 0;
            while (b_out_valid !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        chk("one_valid", {31'b0, b_out_valid}, 32'd1);
        chk("one_last", {31'b0, b_out_last}, 32'd1);
        chk("one_idx", {24'b0, b_out_idx}, 32'd0);
        chk("one_addr", {16'b0, b_mem_addr}, 32'd20);
        chk("one_data", {16'b0, b_out_data}, {16'b0, relu(16'h8000)});
        chk("one_we", {31'b0, b_mem_we}, 32'd0);
        @(negedge clk);
        chk("one_done", {30'b0, b_done, b_busy}, 32'd2);
        chk("one_class_idx", {24'b0, b_class_idx}, 32'd0);
        chk("one_class_val", {16'b0, b_class_val}, {16'b0, relu(16'h8000)});
        b_start = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
